dcache_dm: RTL and testbench
============================

// Module: dcache_dm
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate data cache between the CPU data port and the
//  memory data port. Serves read hits combinationally with zero stall. Read misses fill a full
//  line from memory one word at a time; all writes go through to memory. Raises cpu_stall while
//  memory traffic is outstanding. The instruction port bypasses this block.
// PARAMETERS
//  WORD_SIZE    16  data/address width in bits
//  INDEX_BITS   2   log2(number of lines); 4 lines
//  OFFSET_BITS  2   log2(words per line); 4 words per line; TAG = WORD_SIZE-INDEX_BITS-OFFSET_BITS
// PORTS
//  clk         in   1          clock; all state changes on posedge
//  reset_n     in   1          synchronous, active-low reset
//  cpu_read    in   1          CPU load request; held stable while cpu_stall=1
//  cpu_write   in   1          CPU store request; held stable while cpu_stall=1
//  cpu_addr    in   WORD_SIZE  word address {tag,index,offset}
//  cpu_wdata   in   WORD_SIZE  store data
//  cpu_rdata   out  WORD_SIZE  load data; valid when cpu_read && hit && !cpu_stall
//  cpu_stall   out  1          combinational; CPU must not advance while 1
//  mem_req     out  1          registered; memory access request
//  mem_we      out  1          registered; 1=write, 0=read
//  mem_addr    out  WORD_SIZE  registered access address
//  mem_wdata   out  WORD_SIZE  registered write data
//  mem_rdata   in   WORD_SIZE  read data; valid in the cycle of mem_ready
//  mem_ready   in   1          one-cycle pulse: current access complete; mem_req still high next cycle = new access
//  hit_count   out  16         (DCACHE_STATS_EN only) read-hit counter
//  miss_count  out  16         (DCACHE_STATS_EN only) read-miss counter
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=IDLE, all valid bits 0, mem_req=0, mem_we=0,
//   mem_addr=0, mem_wdata=0, fill counter=0, counters=0. Tag and data arrays are not reset.
//   Reset takes effect mid-FILL or mid-WRITE with no completion; a partial line stays invalid.
//  hit = valid[index] && tag[index]==cpu_addr tag field. cpu_rdata = data[index][offset] (don't-care on miss).
//  FSM IDLE:
//   - cpu_write (has priority over cpu_read) -> WRITE: mem_req=1, mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
//   - cpu_read && !hit -> FILL: cnt=0, mem_req=1, mem_we=0, mem_addr={tag,index,0}.
//   - cpu_read && hit -> stay; cpu_stall=0.
//   - mem_ready is ignored in IDLE.
//  FILL: on mem_ready, data[index][cnt]=mem_rdata.
//   - cnt<LAST: cnt++, mem_addr offset=cnt+1, mem_req stays 1.
//   - cnt==LAST: tag[index]=tag, valid[index]=1, mem_req=0 -> IDLE.
//   Words are fetched in offset order 0..LAST. The CPU retries next cycle and hits.
//   Read-miss stall = LINE_WORDS*memory_latency + 1 cycles.
//  WRITE: on mem_ready, if hit then data[index][offset]=cpu_wdata (valid/tag unchanged).
//   mem_req=0 -> IDLE. Miss: no allocation.
//  cpu_stall = (IDLE&(cpu_write|(cpu_read&!hit))) | FILL | (WRITE&!mem_ready).
//   The store retires on the mem_ready edge.
//  cpu_read=cpu_write=0 in IDLE: no memory traffic, cpu_stall=0.
//  Index and offset wrap naturally by bit slicing. No address range check.
// CONFIGURATION
//  `define DCACHE_STATS_EN: adds hit_count/miss_count, 16-bit, wrap at 2^16, reset to 0.
//   miss_count increments on each IDLE->FILL transition.
//   hit_count increments on an IDLE read hit not immediately following a FILL completion
//   (tracked with a registered just_filled flag).
//   Without the macro, the ports and the logic are absent.
// STRUCTURE
//  Shared package dcache_pkg: WORD_SIZE, INDEX_BITS, OFFSET_BITS, derived TAG_BITS/LINES/LINE_WORDS,
//   FSM state encoding (IDLE=2'd0, FILL=2'd1, WRITE=2'd2).
//  Sub-module dcache_array: tag, valid and data storage with one combinational read port,
//   a word write port, a line-commit port (tag+valid) and a synchronous valid clear.
//  FSM and memory interface live in dcache_dm.
// TESTING (bench memory: mem_ready 2 cycles after each req, init mem[a]=a^16'hA5A5)
//  1 Reset, read 0x0023 -> mem reads 0x0020..0x0023 in order, stall 9 cycles, rdata=0xA586.
//    Then read 0x0021 -> stall 0, rdata=0xA584, no mem_req.
//  2 Write 0x0022<=0x1234 after test 1 -> one mem write, stall until mem_ready, mem[0x22]=0x1234.
//    Then read 0x0022 -> hit, 0x1234.
//  3 Write 0x0050<=0xBEEF on a cold line -> mem updated, no fill.
//    Then read 0x0050 -> miss, fill 0x0050..0x0053, rdata=0xBEEF.
//  4 Read 0x0023, then 0x0063 (same index 0, new tag), then 0x0023 -> three misses, 3 fills.
//  5 reset_n=0 during FILL after 2 words -> next edge mem_req=0, state IDLE.
//    Then read 0x0023 -> full refill from 0x0020.
//  6 With DCACHE_STATS_EN, test 1 -> miss_count=1, hit_count=1.
//    Without it, the bench compiles with no counter ports.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared parameters, address field helpers and FSM encoding for the direct-mapped data cache.
package dcache_pkg;

    localparam int unsigned WORD_SIZE   = 16;
    localparam int unsigned INDEX_BITS  = 2;
    localparam int unsigned OFFSET_BITS = 2;
    localparam int unsigned TAG_BITS    = WORD_SIZE - INDEX_BITS - OFFSET_BITS;
    localparam int unsigned LINES       = 1 << INDEX_BITS;
    localparam int unsigned LINE_WORDS  = 1 << OFFSET_BITS;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFill  = 2'd1,
        StWrite = 2'd2
    } state_e;

    function automatic logic [TAG_BITS-1:0] addr_tag(input logic [WORD_SIZE-1:0] addr);
        return addr[WORD_SIZE-1 -: TAG_BITS];
    endfunction

    function automatic logic [INDEX_BITS-1:0] addr_index(input logic [WORD_SIZE-1:0] addr);
        return addr[OFFSET_BITS +: INDEX_BITS];
    endfunction

    function automatic logic [OFFSET_BITS-1:0] addr_offset(input logic [WORD_SIZE-1:0] addr);
        return addr[OFFSET_BITS-1:0];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag, valid and data storage: one combinational read port, a word write port,
// a line-commit port (tag + valid) and a synchronous clear of all valid bits.
module dcache_array
    import dcache_pkg::*;
(
    input  logic                   clk,
    input  logic                   clear_i,
    input  logic [INDEX_BITS-1:0]  rd_index_i,
    input  logic [OFFSET_BITS-1:0] rd_offset_i,
    output logic [TAG_BITS-1:0]    rd_tag_o,
    output logic                   rd_valid_o,
    output logic [WORD_SIZE-1:0]   rd_data_o,
    input  logic                   wr_en_i,
    input  logic [INDEX_BITS-1:0]  wr_index_i,
    input  logic [OFFSET_BITS-1:0] wr_offset_i,
    input  logic [WORD_SIZE-1:0]   wr_data_i,
    input  logic                   commit_i,
    input  logic [INDEX_BITS-1:0]  commit_index_i,
    input  logic [TAG_BITS-1:0]    commit_tag_i
);

    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [WORD_SIZE-1:0] data_q [LINES][LINE_WORDS];
    logic [LINES-1:0]     valid_q;

    // Tag and data contents are meaningless until the valid bit is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[wr_index_i][wr_offset_i] <= wr_data_i;
        end
        if (commit_i) begin
            tag_q[commit_index_i] <= commit_tag_i;
        end
    end

    always_ff @(posedge clk) begin
        if (clear_i) begin
            valid_q <= '0;
        end else if (commit_i) begin
            valid_q[commit_index_i] <= 1'b1;
        end
    end

    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i][rd_offset_i];

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with line fill on read miss.
// Define DCACHE_STATS_EN to add the hit_count_o / miss_count_o statistics counters.
module dcache_dm
    import dcache_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_read_i,
    input  logic                 cpu_write_i,
    input  logic [WORD_SIZE-1:0] cpu_addr_i,
    input  logic [WORD_SIZE-1:0] cpu_wdata_i,
    output logic [WORD_SIZE-1:0] cpu_rdata_o,
    output logic                 cpu_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [WORD_SIZE-1:0] mem_addr_o,
    output logic [WORD_SIZE-1:0] mem_wdata_o,
    input  logic [WORD_SIZE-1:0] mem_rdata_i,
    input  logic                 mem_ready_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]          hit_count_o,
    output logic [15:0]          miss_count_o
`endif
);

    localparam logic [OFFSET_BITS-1:0] LastWord = OFFSET_BITS'(LINE_WORDS - 1);

    state_e                 state_q, state_d;
    logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [WORD_SIZE-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0]   mem_wdata_q, mem_wdata_d;

    logic [TAG_BITS-1:0]    cpu_tag, arr_tag;
    logic [INDEX_BITS-1:0]  cpu_index;
    logic [OFFSET_BITS-1:0] cpu_offset, arr_wr_offset;
    logic [WORD_SIZE-1:0]   arr_wr_data;
    logic                   arr_valid, arr_wr_en, arr_commit, hit;

    assign cpu_tag    = addr_tag(cpu_addr_i);
    assign cpu_index  = addr_index(cpu_addr_i);
    assign cpu_offset = addr_offset(cpu_addr_i);
    assign hit        = arr_valid && (arr_tag == cpu_tag);

    // The CPU holds its request stable while stalled, so the CPU address names the line
    // being filled or written for the whole transaction.
    dcache_array u_array (
        .clk            (clk),
        .clear_i        (!reset_n),
        .rd_index_i     (cpu_index),
        .rd_offset_i    (cpu_offset),
        .rd_tag_o       (arr_tag),
        .rd_valid_o     (arr_valid),
        .rd_data_o      (cpu_rdata_o),
        .wr_en_i        (arr_wr_en),
        .wr_index_i     (cpu_index),
        .wr_offset_i    (arr_wr_offset),
        .wr_data_i      (arr_wr_data),
        .commit_i       (arr_commit),
        .commit_index_i (cpu_index),
        .commit_tag_i   (cpu_tag)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        cpu_stall_o   = 1'b0;
        arr_wr_en     = 1'b0;
        arr_wr_offset = cpu_offset;
        arr_wr_data   = cpu_wdata_i;
        arr_commit    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu_write_i) begin
                    cpu_stall_o = 1'b1;
                    state_d     = StWrite;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cpu_addr_i;
                    mem_wdata_d = cpu_wdata_i;
                end else if (cpu_read_i && !hit) begin
                    cpu_stall_o = 1'b1;
                    state_d     = StFill;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = {cpu_tag, cpu_index, {OFFSET_BITS{1'b0}}};
                end
            end
            StFill: begin
                cpu_stall_o = 1'b1;
                if (mem_ready_i) begin
                    arr_wr_en     = 1'b1;
                    arr_wr_offset = cnt_q;
                    arr_wr_data   = mem_rdata_i;
                    if (cnt_q == LastWord) begin
                        arr_commit = 1'b1;
                        mem_req_d  = 1'b0;
                        state_d    = StIdle;
                    end else begin
                        cnt_d      = cnt_q + 1'b1;
                        mem_addr_d = {cpu_tag, cpu_index, cnt_q + 1'b1};
                    end
                end
            end
            StWrite: begin
                cpu_stall_o = !mem_ready_i;
                if (mem_ready_i) begin
                    arr_wr_en = hit;
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;
    logic        just_filled_q;

    // The retry right after a fill hits by construction; it belongs to the miss, not the hits.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
            just_filled_q <= 1'b0;
        end else begin
            just_filled_q <= (state_q == StFill) && (state_d == StIdle);
            if (state_q == StIdle && cpu_read_i && !cpu_write_i && hit && !just_filled_q) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (state_q == StIdle && state_d == StFill) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// Randomized scoreboard bench for dcache_dm with a two-cycle memory model and a
// line-level reference model of the cache contents.
module tb_dcache_dm;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_read, cpu_write;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    dcache_dm dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_read_i  (cpu_read),
        .cpu_write_i (cpu_write),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata),
        .cpu_stall_o (cpu_stall),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ready_i (mem_ready)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count_o  (hit_count),
        .miss_count_o (miss_count)
`endif
    );

    typedef struct {
        bit          is_write;
        logic [15:0] addr;
        logic [15:0] data;
        int          stall;
        bit          miss;
    } exp_t;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    bit          ref_valid [4];
    logic [11:0] ref_tag   [4];
    int          ref_hits, ref_misses;

    exp_t        sb[$];
    logic [15:0] rd_log[$];
    logic [15:0] wr_addr_log[$];
    logic [15:0] wr_data_log[$];
    int          stall_cnt;
    int          checks = 0;
    int          errors = 0;
    bit          busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Memory: ready comes in the cycle after a request is first seen; a request still high
    // after completion is a new access.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        busy      = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (busy) begin
                busy = 1'b0;
                if (mem_req) begin
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    else        mem_rdata = mem[mem_addr];
                    mem_ready = 1'b1;
                end
            end else if (mem_req) begin
                busy = 1'b1;
            end
        end
    end

    // Monitor: logs memory completions and scores each CPU access as it retires.
    initial begin
        exp_t        e;
        logic [15:0] fa;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset_n && mem_ready && mem_req) begin
                if (mem_we) begin
                    wr_addr_log.push_back(mem_addr);
                    wr_data_log.push_back(mem_wdata);
                end else begin
                    rd_log.push_back(mem_addr);
                end
            end
            if (reset_n && (cpu_read || cpu_write)) begin
                if (cpu_stall) begin
                    stall_cnt++;
                end else if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_retire: actual addr %0h required no access", cpu_addr);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("stall_cycles@%0h", e.addr), stall_cnt, e.stall);
                    if (e.is_write) begin
                        check("store_mem_writes", wr_addr_log.size(), 1);
                        if (wr_addr_log.size() == 1) begin
                            check("store_addr", wr_addr_log[0], e.addr);
                            check("store_data", wr_data_log[0], e.data);
                        end
                        check("store_mem_reads", rd_log.size(), 0);
                    end else begin
                        check($sformatf("rdata@%0h", e.addr), cpu_rdata, e.data);
                        check("load_mem_reads", rd_log.size(), e.miss ? 4 : 0);
                        if (e.miss && rd_log.size() == 4) begin
                            for (int i = 0; i < 4; i++) begin
                                fa = {e.addr[15:2], 2'b00} + 16'(i);
                                check($sformatf("fill_addr%0d", i), rd_log[i], fa);
                            end
                        end
                        check("load_mem_writes", wr_addr_log.size(), 0);
                    end
                    stall_cnt = 0;
                    rd_log.delete();
                    wr_addr_log.delete();
                    wr_data_log.delete();
                end
            end
        end
    end

    function automatic void clear_ref();
        for (int i = 0; i < 4; i++) ref_valid[i] = 1'b0;
        ref_hits   = 0;
        ref_misses = 0;
    endfunction

    task automatic finish_now();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Issues one access at posedge+1, pushes its expectation and waits for it to retire.
    task automatic do_op(input bit wr, input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        bit   done;
        int   idx;
        idx        = int'(a[3:2]);
        e.is_write = wr;
        e.addr     = a;
        e.miss     = 1'b0;
        if (wr) begin
            ref_mem[a] = d;
            e.data     = d;
            e.stall    = 2;
        end else if (ref_valid[idx] && ref_tag[idx] == a[15:4]) begin
            e.data  = ref_mem[a];
            e.stall = 0;
            ref_hits++;
        end else begin
            e.data         = ref_mem[a];
            e.stall        = 9;
            e.miss         = 1'b1;
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = a[15:4];
            ref_misses++;
        end
        sb.push_back(e);
        cpu_read  = !wr;
        cpu_write = wr;
        cpu_addr  = a;
        cpu_wdata = d;
        done      = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (!cpu_stall) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL op_timeout@%0h: actual still stalled required retire", a);
            finish_now();
        end
        @(posedge clk);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_stats();
`ifdef DCACHE_STATS_EN
        check("hit_count", hit_count, 16'(ref_hits));
        check("miss_count", miss_count, 16'(ref_misses));
`endif
    endtask

    initial begin
        bit          wr;
        logic [15:0] a;
        bit          seen;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'(i) ^ 16'hA5A5;
            ref_mem[i] = 16'(i) ^ 16'hA5A5;
        end
        clear_ref();
        reset_n   = 1'b0;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        idle(2);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_stall", cpu_stall, 0);
        check_stats();
        reset_n = 1'b1;
        idle(1);

        // Cold miss then hit in the same line.
        do_op(0, 16'h0023, '0);
        do_op(0, 16'h0021, '0);
        check_stats();
        // Store hit, read back.
        do_op(1, 16'h0022, 16'h1234);
        check("mem_0022", mem[16'h0022], 16'h1234);
        do_op(0, 16'h0022, '0);
        // Store to a cold line allocates nothing; the later read fills the stored word.
        do_op(1, 16'h0050, 16'hBEEF);
        check("mem_0050", mem[16'h0050], 16'hBEEF);
        do_op(0, 16'h0050, '0);
        // Conflict on index 0.
        do_op(0, 16'h0023, '0);
        do_op(0, 16'h0063, '0);
        do_op(0, 16'h0023, '0);

        // Reset in the middle of a fill.
        ref_misses++;
        cpu_read = 1'b1;
        cpu_addr = 16'h0093;
        seen     = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (rd_log.size() >= 2) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL abort_wait: actual %0d words required 2", rd_log.size());
            finish_now();
        end
        reset_n  = 1'b0;
        cpu_read = 1'b0;
        @(posedge clk);
        #1;
        check("abort_mem_req", mem_req, 0);
        check("abort_idle", cpu_stall, 0);
        check("abort_mem_addr", mem_addr, 0);
        reset_n = 1'b1;
        clear_ref();
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        stall_cnt = 0;
        do_op(0, 16'h0023, '0);

        for (int k = 0; k < 150; k++) begin
            wr = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) a = 16'hFFF0 | 16'($urandom_range(0, 15));
            else                           a = 16'($urandom_range(0, 63));
            do_op(wr, a, 16'($urandom));
            idle($urandom_range(0, 2));
        end
        check_stats();
        check("scoreboard_drained", sb.size(), 0);
        finish_now();
    end

endmodule
